// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the PC onto a 1-cycle synchronous ROM,
// tags returned words with their address, and hands them to decode through
// a one-entry valid/ready register. Stalls are realised by replaying the PC
// via its start port; go starts a program and a halt opcode ends it.
module instr_fetch #(
    parameter int                     ROM_SIZE    = 512,
    parameter int                     INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 9'h1FF,
    // derived from ROM_SIZE to match the PC width; not meant to be overridden
    parameter int                     AW          = $clog2(ROM_SIZE) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [AW-1:0]          go_addr,
    input  logic [AW-1:0]          pc_in,
    output logic                   pc_start,
    output logic [AW-1:0]          pc_start_addr,
    output logic [AW-1:0]          rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [AW-1:0]          instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [AW-1:0]          a_q, a_d;       // address of the word now on rom_data
    logic                   a_v_q, a_v_d;   // that word is wanted
    logic [INSTR_WIDTH-1:0] out_q, out_d;
    logic [AW-1:0]          ipc_q, ipc_d;
    logic                   vld_q, vld_d;
    logic                   done_q, done_d;

    logic run, go_ok, fire, stall, capture;

    assign rom_addr    = pc_in;
    assign instr_out   = out_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = vld_q;
    assign done        = done_q;

    // Per-cycle qualifiers and the PC replay/start request.
    always_comb begin
        run     = (state_q == S_RUN);
        go_ok   = !run && go;
        fire    = vld_q && instr_ready;
        stall   = run && vld_q && !instr_ready && !flush;
        capture = run && a_v_q && !flush && (!vld_q || instr_ready);
        // While stalled, re-point the PC at the oldest address not yet
        // captured: the in-flight word if there is one, else the held PC.
        pc_start      = rst_n && (go_ok || stall);
        pc_start_addr = go_ok ? go_addr : (a_v_q ? a_q : pc_in);
    end

    // Next-state logic: go > flush > stall > capture.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;
        done_d  = done_q;
        a_d     = run ? pc_in : a_q;
        // A replayed or flushed cycle fetches a word nobody will take.
        a_v_d   = run && !stall && !flush;

        if (go_ok) begin
            state_d = S_RUN;
            done_d  = 1'b0;
            vld_d   = 1'b0;
        end else begin
            if (flush) begin
                vld_d = 1'b0;
            end else if (capture) begin
                out_d = rom_data;
                ipc_d = a_q;
                vld_d = 1'b1;
                if (rom_data == HALT_OPCODE) state_d = S_HALT;
            end else if (fire) begin
                vld_d = 1'b0;
            end

            if (state_q == S_HALT) begin
                // The only word presentable in HALT is the halt word itself.
                if (fire)               done_d  = 1'b1;
                else if (flush && vld_q) state_d = S_RUN;
            end else if (state_q != S_RUN) begin
                state_d = S_IDLE;
            end
        end
    end

    // State registers; reset drops every valid flag immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            a_v_q   <= 1'b0;
            out_q   <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            a_v_q   <= a_v_d;
            out_q   <= out_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small PC model and synchronous ROM.
module tb_instr_fetch;

    localparam int AW = 10;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [AW-1:0] go_addr;
    logic [AW-1:0] pc_in;
    logic          pc_start;
    logic [AW-1:0] pc_start_addr;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          flush;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          done;

    // branch side of the PC model
    logic          br;
    logic [AW-1:0] br_tgt;

    logic [IW-1:0] rom [512];

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .go(go), .go_addr(go_addr), .pc_in(pc_in),
        .pc_start(pc_start), .pc_start_addr(pc_start_addr), .rom_addr(rom_addr),
        .rom_data(rom_data), .flush(flush), .instr_out(instr_out),
        .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .done(done)
    );

    always #5 clk = ~clk;

    // PC: start load beats a taken branch beats increment.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc_in <= '0;
        else if (pc_start) pc_in <= pc_start_addr;
        else if (br)       pc_in <= br_tgt;
        else               pc_in <= pc_in + 1'b1;
    end

    // 1-cycle synchronous ROM
    always @(posedge clk) rom_data <= rom[rom_addr[8:0]];

    function automatic logic [IW-1:0] romv(input int a);
        logic [IW-1:0] v;
        v = 9'(a) ^ 9'h0A5;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input int a);
        chk({tag, "_v"},  32'(instr_valid), 32'd1);
        chk({tag, "_pc"}, 32'(instr_pc),    32'(a));
        chk({tag, "_d"},  32'(instr_out),   32'(rom[a]));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = romv(i);
        rom[9'h15A] = 9'h0AA;   // keep HALT only where intended
        rom[9'h020] = 9'h1FF;

        rst_n = 1'b0; go = 1'b0; go_addr = '0; flush = 1'b0;
        instr_ready = 1'b1; br = 1'b0; br_tgt = '0;

        // reset: go must not reach the PC while reset is held
        #2; go = 1'b1; #1;
        chk("rst_pcstart", 32'(pc_start),    32'd0);
        chk("rst_valid",   32'(instr_valid), 32'd0);
        chk("rst_done",    32'(done),        32'd0);
        go = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("idle_valid",   32'(instr_valid), 32'd0);
        chk("idle_pcstart", 32'(pc_start),    32'd0);

        // start at 0x010
        go = 1'b1; go_addr = 10'h010; #1;
        chk("go_pcstart", 32'(pc_start),      32'd1);
        chk("go_addr",    32'(pc_start_addr), 32'h010);
        tick; go = 1'b0; #1;
        chk("go_e1_valid",   32'(instr_valid), 32'd0);
        chk("go_e1_pcstart", 32'(pc_start),    32'd0);
        tick;
        chk("go_e2_valid", 32'(instr_valid), 32'd0);
        tick; chk_word("w010", 'h010);
        tick; chk_word("w011", 'h011);
        tick; chk_word("w012", 'h012);

        // three stalled cycles holding 0x012
        instr_ready = 1'b0; #1;
        chk("st1_pcstart", 32'(pc_start),      32'd1);
        chk("st1_addr",    32'(pc_start_addr), 32'h013);
        for (int k = 0; k < 2; k++) begin
            tick;
            chk_word("st_hold", 'h012);
            chk("st_pcstart", 32'(pc_start),      32'd1);
            chk("st_addr",    32'(pc_start_addr), 32'h013);
        end
        instr_ready = 1'b1; #1;
        chk("rel_pcstart", 32'(pc_start), 32'd0);
        tick; chk("bubble_valid", 32'(instr_valid), 32'd0);
        tick; chk_word("w013", 'h013);
        tick; chk_word("w014", 'h014);
        tick; chk_word("w015", 'h015);

        // flush with 0x016 in flight; PC branches to 0x030
        flush = 1'b1; br = 1'b1; br_tgt = 10'h030; #1;
        chk("fl_pcstart", 32'(pc_start), 32'd0);
        tick; flush = 1'b0; br = 1'b0; #1;
        chk("fl_valid", 32'(instr_valid), 32'd0);
        tick; chk("fl_valid2", 32'(instr_valid), 32'd0);
        tick; chk_word("w030", 'h030);

        // branch to 0x01E and run into the halt word at 0x020
        flush = 1'b1; br = 1'b1; br_tgt = 10'h01E;
        tick; flush = 1'b0; br = 1'b0;
        tick;
        tick; chk_word("w01e", 'h01E);
        tick;
        tick; chk_word("whalt", 'h020);
        instr_ready = 1'b0; #1;
        chk("halt_pcstart", 32'(pc_start), 32'd0);
        chk("halt_done0",   32'(done),     32'd0);
        tick; chk_word("halt_hold", 'h020);
        chk("halt_done1", 32'(done), 32'd0);
        instr_ready = 1'b1; #1;
        chk("halt_fire_done", 32'(done), 32'd0);
        tick;
        chk("done_set",    32'(done),        32'd1);
        chk("done_valid",  32'(instr_valid), 32'd0);
        tick; chk("halt_nocap1", 32'(instr_valid), 32'd0);
        tick; chk("halt_nocap2", 32'(instr_valid), 32'd0);
        chk("done_hold", 32'(done), 32'd1);

        // restart at 0x000
        go = 1'b1; go_addr = 10'h000; #1;
        chk("rego_pcstart", 32'(pc_start),      32'd1);
        chk("rego_addr",    32'(pc_start_addr), 32'h000);
        tick; go = 1'b0; #1;
        chk("rego_done", 32'(done), 32'd0);
        tick;
        tick; chk_word("w000", 'h000);

        // stall and flush together: flush wins
        instr_ready = 1'b0; flush = 1'b1; br = 1'b1; br_tgt = 10'h040; #1;
        chk("sf_pcstart", 32'(pc_start), 32'd0);
        tick; flush = 1'b0; br = 1'b0; instr_ready = 1'b1; #1;
        chk("sf_valid", 32'(instr_valid), 32'd0);
        tick;
        tick; chk_word("w040", 'h040);

        // reset in the middle of a stall
        instr_ready = 1'b0; #1;
        chk("rs_pcstart", 32'(pc_start),      32'd1);
        chk("rs_addr",    32'(pc_start_addr), 32'h041);
        rst_n = 1'b0; #1;
        chk("rs_valid",    32'(instr_valid), 32'd0);
        chk("rs_pcstart0", 32'(pc_start),    32'd0);
        chk("rs_pc",       32'(instr_pc),    32'd0);
        tick; tick;
        rst_n = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("rs_idle_valid", 32'(instr_valid), 32'd0);
            chk("rs_idle_pcst",  32'(pc_start),    32'd0);
        end

        // restart, then reset while streaming
        go = 1'b1; go_addr = 10'h005;
        tick; go = 1'b0;
        tick;
        tick; chk_word("w005", 'h005);
        tick; chk_word("w006", 'h006);
        rst_n = 1'b0; #1;
        chk("rm_valid", 32'(instr_valid), 32'd0);
        chk("rm_out",   32'(instr_out),   32'd0);
        chk("rm_pc",    32'(instr_pc),    32'd0);
        tick; rst_n = 1'b1;
        tick; tick;
        chk("rm_idle_valid", 32'(instr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly downstream of the program counter. Each cycle it drives the PC value onto a synchronous instruction ROM (1-cycle read latency). It tags returned words with their address and presents them to decode through a one-entry valid/ready output register. The PC has no hold input, so stalls are implemented by replaying the PC through its start/start_addr port; the block also sequences program start (go) and program end (halt opcode).

Parameters:
ROM_SIZE, 512, instruction ROM depth; address width AW = $clog2(ROM_SIZE)+1 (matches PC width)
INSTR_WIDTH, 9, instruction word width
HALT_OPCODE, 9'h1FF, instruction encoding that ends the program

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
go  in  1  start program (honoured in IDLE/HALT only)
go_addr  in  AW  first instruction address
pc_in  in  AW  current PC value
pc_start  out  1  to PC start; forces PC load next edge
pc_start_addr  out  AW  to PC start_addr
rom_addr  out  AW  ROM read address (= pc_in, combinational)
rom_data  in  INSTR_WIDTH  ROM read data, valid the cycle after rom_addr
flush  in  1  taken branch resolved downstream; discard fetched work
instr_out  out  INSTR_WIDTH  fetched instruction
instr_pc  out  AW  address of instr_out
instr_valid  out  1  instr_out/instr_pc valid
instr_ready  in  1  decode accepts instr_out this cycle
done  out  1  halt instruction consumed; program finished

Behaviour:
- States: IDLE, RUN, HALT. Reset (async, rst_n=0) forces IDLE; instr_valid=0, instr_out=0, instr_pc=0, done=0, in-flight valid a_v=0, a_q=0. pc_start=0 while rst_n=0.
- In-flight slot: a_q/a_v. Each edge in RUN: a_q<=pc_in; a_v<=!(pc_start||flush). Outside RUN: a_v<=0.
- IDLE/HALT with go=1: pc_start=1, pc_start_addr=go_addr (combinational), next state RUN, done<=0, instr_valid<=0. First instr_valid rises 2 edges after the edge sampling go. go is ignored in RUN.
- Consume: fire = instr_valid && instr_ready. On fire with no capture, instr_valid<=0.
- Capture (RUN only): when a_v && !flush && (!instr_valid || instr_ready), load instr_out<=rom_data, instr_pc<=a_q, instr_valid<=1.
- Stall: stall = (state==RUN) && instr_valid && !instr_ready && !flush. While stall=1: pc_start=1, pc_start_addr = a_v ? a_q : pc_in. The dropped in-flight word is refetched and the PC is held at that address every stalled cycle. After release there is exactly one bubble cycle, then sequential delivery resumes with no lost or duplicated address.
- Flush: flush=1 clears instr_valid and a_v at the next edge. It suppresses capture and stall replay, so pc_start=0 and the PC's taken redirect is never overridden. A fire in the flush cycle is still a valid consume. In HALT with the halt word still unconsumed, flush returns to RUN.
- Halt: capturing a word equal to HALT_OPCODE moves RUN->HALT. In HALT, capture is disabled and a_v<=0; the halt word stays presented until fired. The fire of the halt word sets done<=1. done holds until go or reset.
- Priority per cycle: reset > go (IDLE/HALT) > flush > stall > capture.
- Arithmetic: no address arithmetic here; widths are fixed at AW, and wrap-around is the PC's responsibility.
- Reset mid-operation: immediate return to IDLE. All valid flags drop asynchronously. A ROM word in flight is discarded.

Test Plan:
- Reset with go held low -> IDLE, instr_valid=0, done=0, pc_start=0. Pulse go, go_addr=0x010 -> pc_start=1 with addr 0x010 that cycle; instr_valid rises 2 edges later with instr_pc=0x010, then 0x011, 0x012 on consecutive cycles (ready=1).
- Streaming, ready low 3 cycles while holding 0x012 -> instr_out and instr_pc held stable; pc_start=1 with addr 0x013 each stalled cycle; after release, one bubble, then 0x013, 0x014; no address skipped or repeated.
- flush asserted while 0x015 is valid and 0x016 is in flight (PC redirected to 0x030 by its own taken input) -> pc_start=0, instr_valid=0 next cycle, next delivered instr_pc=0x030.
- ROM[0x020]=HALT_OPCODE, with ready low 2 cycles on the halt word -> state HALT, no further captures; done rises only on the edge after fire. A second go to 0x000 clears done and restarts.
- Stall and flush in the same cycle -> flush wins: pc_start=0 and all valid flags cleared.
- rst_n pulsed low mid-stream and mid-stall -> outputs clear asynchronously, state IDLE, nothing delivered until the next go.
